// File: rtl/uart_tx_buffered_if.sv
// Byte-write side and status/line outputs of the buffered UART transmitter.
// Valid/ready: a byte is taken on any rising edge with tx_wr=1 and tx_full=0; with tx_full=1 it is dropped and flagged.
interface uart_tx_buffered_if;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_overflow;
  logic       UART_TX;
  logic [1:0] dbg_state;

  modport master (
    output tx_wr, tx_data,
    input  tx_full, tx_empty, tx_busy, tx_done, tx_overflow, UART_TX, dbg_state
  );

  modport slave (
    input  tx_wr, tx_data,
    output tx_full, tx_empty, tx_busy, tx_done, tx_overflow, UART_TX, dbg_state
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with its own baud divider and a small write FIFO.
// Queued bytes go out back-to-back; dbg_state exposes the FSM state.
module uart_tx_buffered #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int FIFO_AW  = 2
) (
  input  logic          sysclk,
  input  logic          reset,
  uart_tx_buffered_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, empty, wr_en, pop;
  logic               overflow_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               done;
  logic               baud_end;

  assign full     = (count_q == (FIFO_AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  // A full FIFO drops the write even when the FSM pops on the same edge.
  assign wr_en    = bus.tx_wr & ~full;
  assign baud_end = (baud_q == CNT_W'(BAUD_DIV - 1));

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
      if (bus.tx_wr && full) overflow_q <= 1'b1;
    end
  end

  // tx_d always carries the line level of the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          done   = 1'b1;
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx_full     = full;
  assign bus.tx_empty    = empty;
  assign bus.tx_busy     = (state_q != S_IDLE);
  assign bus.tx_done     = done;
  assign bus.tx_overflow = overflow_q;
  assign bus.UART_TX     = tx_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: a line monitor decodes frames and
// compares them against the expected-byte queue filled by the stimulus.
module tb_uart_tx_buffered;
  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  uart_tx_buffered_if bus();

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100), .FIFO_AW(2)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  logic [7:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int low_cyc  = 0;
  int viol     = 0;
  int rst_cnt  = 0;
  int frames   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_wr(input logic [7:0] d, input bit expect_it);
    @(negedge sysclk);
    bus.tx_wr   = 1'b1;
    bus.tx_data = d;
    if (expect_it) exp_q.push_back(d);
  endtask

  task automatic end_wr();
    @(negedge sysclk);
    bus.tx_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sysclk);
      if (bus.tx_busy === 1'b0 && bus.tx_empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  // Activity counters sampled away from the active edge.
  always @(negedge sysclk) begin
    if (bus.tx_done === 1'b1) begin
      done_cnt++;
      if (bus.dbg_state === 2'd0 || bus.dbg_state === 2'd1) viol++;
    end
    if (bus.tx_busy === 1'b1) busy_cyc++;
    if (bus.UART_TX === 1'b0) low_cyc++;
  end

  always @(posedge sysclk) if (reset) rst_cnt++;

  // Line monitor: decode each 8N1 frame at mid-bit and score it.
  int         mon_r0;
  logic [7:0] mon_b;
  logic       mon_sb, mon_pb;
  initial begin : monitor
    forever begin
      @(negedge sysclk);
      if (bus.UART_TX === 1'b0 && reset === 1'b0) begin
        mon_r0 = rst_cnt;
        repeat (4) @(negedge sysclk);
        mon_sb = bus.UART_TX;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge sysclk);
          mon_b[i] = bus.UART_TX;
        end
        repeat (10) @(negedge sysclk);
        mon_pb = bus.UART_TX;
        if (rst_cnt == mon_r0) begin
          frames++;
          check("start_bit", mon_sb, 1'b0);
          check("stop_bit", mon_pb, 1'b1);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: got %0h expected none", mon_b);
          end else begin
            check("frame_byte", mon_b, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  int d0, b0, l0, f0, hits, pos;

  initial begin : stim
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;

    // Reset state
    check("rst_uart_tx", bus.UART_TX, 1'b1);
    check("rst_busy", bus.tx_busy, 1'b0);
    check("rst_done", bus.tx_done, 1'b0);
    check("rst_overflow", bus.tx_overflow, 1'b0);
    check("rst_empty", bus.tx_empty, 1'b1);
    check("rst_full", bus.tx_full, 1'b0);

    // 1: single byte 0x55, latency and tx_done position
    d0 = done_cnt;
    push_wr(8'h55, 1'b1);
    @(posedge sysclk); #1;
    check("t1_tx_at_e0", bus.UART_TX, 1'b1);
    check("t1_empty_at_e0", bus.tx_empty, 1'b0);
    end_wr();
    @(posedge sysclk); #1;
    check("t1_tx_fall_e1", bus.UART_TX, 1'b0);
    check("t1_busy_e1", bus.tx_busy, 1'b1);
    hits = 0; pos = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge sysclk);
      if (bus.tx_done === 1'b1) begin
        hits++;
        pos = i;
      end
    end
    check("t1_done_hits", hits, 1);
    check("t1_done_cycle", pos, 100);
    @(negedge sysclk);
    check("t1_busy_after", bus.tx_busy, 1'b0);
    check("t1_tx_after", bus.UART_TX, 1'b1);
    check("t1_done_total", done_cnt - d0, 1);

    // 2: three back-to-back frames, no idle gap
    d0 = done_cnt; b0 = busy_cyc;
    push_wr(8'hA3, 1'b1);
    push_wr(8'h0F, 1'b1);
    push_wr(8'hFF, 1'b1);
    end_wr();
    wait_idle("t2_idle_timeout");
    check("t2_busy_cycles", busy_cyc - b0, 300);
    check("t2_done_count", done_cnt - d0, 3);

    // 3: six writes from idle; sixth is dropped
    d0 = done_cnt;
    for (int i = 1; i <= 6; i++) begin
      push_wr(8'(i), i <= 5);
      @(posedge sysclk); #1;
      if (i == 5) check("t3_full_after5", bus.tx_full, 1'b1);
      if (i == 5) check("t3_ovf_after5", bus.tx_overflow, 1'b0);
      if (i == 6) check("t3_ovf_after6", bus.tx_overflow, 1'b1);
    end
    end_wr();
    wait_idle("t3_idle_timeout");
    check("t3_done_count", done_cnt - d0, 5);
    check("t3_ovf_sticky", bus.tx_overflow, 1'b1);

    // 4: write on the STOP->START pop edge with the FIFO full
    do_reset();
    check("t4_ovf_cleared", bus.tx_overflow, 1'b0);
    d0 = done_cnt;
    push_wr(8'h11, 1'b1);
    push_wr(8'h22, 1'b1);
    push_wr(8'h33, 1'b1);
    push_wr(8'h44, 1'b1);
    push_wr(8'h5A, 1'b1);
    end_wr();
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (bus.tx_done === 1'b1) begin
        hits = 1;
        break;
      end
    end
    check("t4_done_seen", hits, 1);
    check("t4_full_before", bus.tx_full, 1'b1);
    bus.tx_wr   = 1'b1;
    bus.tx_data = 8'hEE;
    @(posedge sysclk); #1;
    check("t4_ovf_set", bus.tx_overflow, 1'b1);
    check("t4_full_after_pop", bus.tx_full, 1'b0);
    check("t4_empty_after_pop", bus.tx_empty, 1'b0);
    end_wr();
    wait_idle("t4_idle_timeout");
    check("t4_done_count", done_cnt - d0, 5);

    // 5: reset in the middle of DATA bit 4 with two bytes queued
    do_reset();
    push_wr(8'h81, 1'b0);
    push_wr(8'h82, 1'b0);
    push_wr(8'h83, 1'b0);
    end_wr();
    repeat (53) @(negedge sysclk);
    check("t5_in_data", bus.dbg_state, 2'd2);
    d0 = done_cnt; f0 = frames;
    reset = 1'b1;
    @(posedge sysclk); #1;
    check("t5_tx_high", bus.UART_TX, 1'b1);
    check("t5_busy_low", bus.tx_busy, 1'b0);
    check("t5_empty", bus.tx_empty, 1'b1);
    @(negedge sysclk);
    reset = 1'b0;
    l0 = low_cyc;
    repeat (300) @(negedge sysclk);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_line_idle", low_cyc - l0, 0);
    check("t5_no_frames", frames - f0, 0);

    // 6: long idle after reset
    do_reset();
    d0 = done_cnt; b0 = busy_cyc; l0 = low_cyc; hits = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sysclk);
      if (bus.dbg_state !== 2'd0) hits++;
    end
    check("t6_done", done_cnt - d0, 0);
    check("t6_busy", busy_cyc - b0, 0);
    check("t6_line", low_cyc - l0, 0);
    check("t6_state_idle", hits, 0);

    check("exp_q_drained", exp_q.size(), 0);
    check("done_in_idle_or_start", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
